device_event_encoder: RTL and testbench

Front end that feeds the active IoT devices monitor. It watches N_DEV device status lines and detects each device turning on or off. It serialises those transitions into the monitor's single-event interface: one change pulse per cycle, with on_off giving the direction. It keeps a shadow copy of the status last reported to the monitor, so no transition is lost or double-counted when several devices toggle together.

---
 rtl/device_event_if.sv | 34 +++
 rtl/device_event_encoder.sv | 85 ++++++++
 tb/tb_device_event_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/device_event_if.sv
// Bundle between the device status front end and the active-devices monitor:
// device levels and enable in, serialised change events and status out.
interface device_event_if #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
);
  logic [N_DEV-1:0] dev_status;
  logic             enable;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic [7:0]       active_count;
  logic             pending;

  modport master (
    input  dev_status,
    input  enable,
    output change,
    output on_off,
    output dev_id,
    output active_count,
    output pending
  );

  modport slave (
    output dev_status,
    output enable,
    input  change,
    input  on_off,
    input  dev_id,
    input  active_count,
    input  pending
  );
endinterface

// File: rtl/device_event_encoder.sv
// Serialises per-device on/off transitions into one change event per cycle,
// round-robin, against a shadow copy of the status already reported.
module device_event_encoder #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  device_event_if.master ev
);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_DEV - 1);
  localparam logic [ID_W:0]   N_DEV_EXT = (ID_W + 1)'(N_DEV);

  logic [N_DEV-1:0] status_q;
  logic [N_DEV-1:0] reported;
  logic [N_DEV-1:0] diff;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ptr_next;
  logic             any_diff;
  logic             win_level;
  logic             emit;

  logic             change_q;
  logic             on_off_q;
  logic [ID_W-1:0]  dev_id_q;
  logic [7:0]       active_count_q;

  // Index base+off taken modulo N_DEV; off never exceeds N_DEV-1.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= N_DEV_EXT) sum = sum - N_DEV_EXT;
    return sum[ID_W-1:0];
  endfunction

  assign diff     = status_q ^ reported;
  assign any_diff = |diff;
  assign emit     = ev.enable && any_diff;

  // Walk offsets from the far end so the nearest pending device to ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx    = '0;
    winner = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      idx = wrap_idx(ptr, (ID_W + 1)'(k));
      if (diff[idx]) winner = idx;
    end
  end

  assign win_level = status_q[winner];
  assign ptr_next  = (winner == LAST_ID) ? '0 : winner + ID_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q       <= '0;
      reported       <= '0;
      ptr            <= '0;
      change_q       <= 1'b0;
      on_off_q       <= 1'b0;
      dev_id_q       <= '0;
      active_count_q <= '0;
    end else begin
      status_q <= ev.dev_status;
      change_q <= 1'b0;
      if (emit) begin
        change_q         <= 1'b1;
        dev_id_q         <= winner;
        on_off_q         <= win_level;
        reported[winner] <= win_level;
        ptr              <= ptr_next;
        active_count_q   <= win_level ? active_count_q + 8'd1
                                      : active_count_q - 8'd1;
      end
    end
  end

  assign ev.change       = change_q;
  assign ev.on_off       = on_off_q;
  assign ev.dev_id       = dev_id_q;
  assign ev.active_count = active_count_q;
  assign ev.pending      = any_diff;
endmodule

// File: tb/tb_device_event_encoder.sv
// Directed bench for device_event_encoder: reset, single events, bursts,
// hold/cancel, round-robin order and asynchronous reset mid-burst.
module tb_device_event_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  device_event_if #(.N_DEV(8), .ID_W(3)) ev ();

  device_event_encoder #(.N_DEV(8), .ID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .ev  (ev)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ev.dev_status = 8'h00;
    ev.enable = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // {change, on_off, dev_id, active_count}
  function automatic logic [12:0] obs();
    return {ev.change, ev.on_off, ev.dev_id, ev.active_count};
  endfunction

  task automatic test_reset();
    ev.dev_status = 8'h00;
    ev.enable = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({ev.change, ev.on_off, ev.dev_id, ev.active_count, ev.pending} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected 0", {ev.change, ev.on_off, ev.dev_id, ev.active_count, ev.pending});
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if ({ev.change, ev.active_count, ev.pending} !== 10'h0) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d: change=%b count=%0d pending=%b expected all 0", i, ev.change, ev.active_count, ev.pending);
      end
    end
  endtask

  task automatic test_single();
    ev.dev_status = 8'h08;
    tick();
    tests_run++;
    if ({ev.change, ev.pending} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_on_capture: change=%b pending=%b expected 0 1", ev.change, ev.pending);
    end
    tick();
    tests_run++;
    if ({obs(), ev.pending} !== {1'b1, 1'b1, 3'd3, 8'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_on_event: got %h expected %h", {obs(), ev.pending}, {1'b1, 1'b1, 3'd3, 8'd1, 1'b0});
    end
    tick();
    tests_run++;
    if (ev.change !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_on_one_pulse: change=%b expected 0", ev.change);
    end
    ev.dev_status = 8'h00;
    tick();
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b0, 3'd3, 8'd0}) begin
      tests_failed++;
      $display("FAIL single_off_event: got %h expected %h", obs(), {1'b1, 1'b0, 3'd3, 8'd0});
    end
    tick();
    tests_run++;
    if ({ev.change, ev.pending} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_off_one_pulse: change=%b pending=%b expected 0 0", ev.change, ev.pending);
    end
  endtask

  task automatic test_burst();
    do_reset();
    ev.dev_status = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (obs() !== {1'b1, 1'b1, 3'(i), 8'(i + 1)}) begin
        tests_failed++;
        $display("FAIL burst_event%0d: got %h expected %h", i, obs(), {1'b1, 1'b1, 3'(i), 8'(i + 1)});
      end
    end
    tick();
    tests_run++;
    if ({ev.change, ev.pending, ev.active_count} !== {1'b0, 1'b0, 8'd8}) begin
      tests_failed++;
      $display("FAIL burst_end: change=%b pending=%b count=%0d expected 0 0 8", ev.change, ev.pending, ev.active_count);
    end
  endtask

  task automatic test_hold_cancel();
    do_reset();
    ev.enable = 1'b0;
    ev.dev_status = 8'h24;
    tick();
    ev.dev_status = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (ev.change !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_no_pulse%0d: change=%b expected 0", i, ev.change);
      end
    end
    tests_run++;
    if (ev.pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_pending: pending=%b expected 1", ev.pending);
    end
    ev.enable = 1'b1;
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd5, 8'd1}) begin
      tests_failed++;
      $display("FAIL hold_release_event: got %h expected %h", obs(), {1'b1, 1'b1, 3'd5, 8'd1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({ev.change, ev.pending, ev.active_count} !== {1'b0, 1'b0, 8'd1}) begin
        tests_failed++;
        $display("FAIL cancel_no_event%0d: change=%b pending=%b count=%0d expected 0 0 1", i, ev.change, ev.pending, ev.active_count);
      end
    end
  endtask

  task automatic test_round_robin();
    // Reporting device 1 leaves ptr at 2.
    ev.dev_status = 8'h22;
    tick();
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd1, 8'd2}) begin
      tests_failed++;
      $display("FAIL rr_setup: got %h expected %h", obs(), {1'b1, 1'b1, 3'd1, 8'd2});
    end
    ev.dev_status = 8'h60;
    tick();
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd6, 8'd3}) begin
      tests_failed++;
      $display("FAIL rr_first: got %h expected %h", obs(), {1'b1, 1'b1, 3'd6, 8'd3});
    end
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b0, 3'd1, 8'd2}) begin
      tests_failed++;
      $display("FAIL rr_second: got %h expected %h", obs(), {1'b1, 1'b0, 3'd1, 8'd2});
    end
    // ptr should now be 2: devices 0 and 3 come out as 3 then 0.
    ev.dev_status = 8'h69;
    tick();
    tests_run++;
    if ({ev.change, ev.pending} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rr_gap: change=%b pending=%b expected 0 1", ev.change, ev.pending);
    end
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd3, 8'd3}) begin
      tests_failed++;
      $display("FAIL rr_ptr_first: got %h expected %h", obs(), {1'b1, 1'b1, 3'd3, 8'd3});
    end
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd0, 8'd4}) begin
      tests_failed++;
      $display("FAIL rr_ptr_second: got %h expected %h", obs(), {1'b1, 1'b1, 3'd0, 8'd4});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ev.dev_status = 8'h0F;
    tick();
    tick();
    tests_run++;
    if (obs() !== {1'b1, 1'b1, 3'd0, 8'd1}) begin
      tests_failed++;
      $display("FAIL areset_pre_event: got %h expected %h", obs(), {1'b1, 1'b1, 3'd0, 8'd1});
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({obs(), ev.pending} !== 14'h0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %h expected 0", {obs(), ev.pending});
    end
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({ev.change, ev.pending, ev.active_count} !== {1'b0, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL areset_recapture: change=%b pending=%b count=%0d expected 0 1 0", ev.change, ev.pending, ev.active_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (obs() !== {1'b1, 1'b1, 3'(i), 8'(i + 1)}) begin
        tests_failed++;
        $display("FAIL areset_event%0d: got %h expected %h", i, obs(), {1'b1, 1'b1, 3'(i), 8'(i + 1)});
      end
    end
    tick();
    tests_run++;
    if ({ev.change, ev.pending, ev.active_count} !== {1'b0, 1'b0, 8'd4}) begin
      tests_failed++;
      $display("FAIL areset_end: change=%b pending=%b count=%0d expected 0 0 4", ev.change, ev.pending, ev.active_count);
    end
  endtask

  initial begin
    ev.dev_status = 8'h00;
    ev.enable = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_hold_cancel();
    test_round_robin();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
